// File: rtl/spi_pkg.sv
// Shared SPI definitions: bus mode encoding, byte width and
// the controller state encoding used by spi_controller.
package spi_pkg;

    localparam int unsigned SPI_BYTE_W = 8;

    typedef enum logic [1:0] {
        SPI_MODE0 = 2'd0,
        SPI_MODE1 = 2'd1,
        SPI_MODE2 = 2'd2,
        SPI_MODE3 = 2'd3
    } spi_mode_e;

    localparam spi_mode_e SPI_MODE = SPI_MODE0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOW,
        ST_HIGH,
        ST_HOLD,
        ST_GAP
    } spi_state_e;

    function automatic logic spi_cpol(input spi_mode_e mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/spi_clock_divider.sv
// Half-period timer: counts while enabled and flags the first,
// next-to-last and last cycle of each SCK phase.
module spi_clock_divider #(
    parameter int unsigned HALF_PERIOD = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic first_o,
    output logic pre_end_o,
    output logic end_o
);

    localparam logic [7:0] LAST = 8'(HALF_PERIOD - 1);
    localparam logic [7:0] PRE  = 8'(HALF_PERIOD - 2);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign first_o   = en_i && (cnt_q == 8'd0);
    assign pre_end_o = en_i && (cnt_q == PRE);
    assign end_o     = en_i && (cnt_q == LAST);

    // Restart at zero when idle or at the end of a phase
    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (!en_i || end_o) begin
            cnt_d = 8'd0;
        end
    end

    // Phase counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 controller: address byte then length_in data bytes,
// MSB first, with tx handshake and per-byte rx pulses.
module spi_controller
    import spi_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_in,
    input  logic [7:0] address_in,
    input  logic [7:0] length_in,
    input  logic [7:0] tx_data_in,
    input  logic       tx_data_in_valid,
    output logic       tx_data_in_ready,
    output logic [7:0] rx_data_out,
    output logic       rx_data_out_valid,
    output logic       busy_out,
    output logic       done_out,
    output logic       spi_select_out,
    output logic       spi_clock_out,
    output logic       spi_data_out,
    input  logic       spi_data_in
);

    localparam logic CPOL = spi_cpol(SPI_MODE);

    spi_state_e state_q;
    logic [7:0] addr_q;
    logic [6:0] sr_q;
    logic [6:0] rxsr_q;
    logic [7:0] rx_q;
    logic       rxv_q;
    logic       done_q;
    logic       busy_q;
    logic       sel_q;
    logic       sck_q;
    logic       mosi_q;
    logic       ready_q;
    logic [2:0] bit_q;
    logic [8:0] byte_q;
    logic [8:0] total_q;

    logic first_byte;
    logic div_en;
    logic ph_first;
    logic ph_pre;
    logic ph_end;

    assign first_byte = (byte_q == 9'd0);

    // The address LOAD is timed so select leads the first SCK edge
    // by a half period; data LOADs wait only on the tx handshake.
    assign div_en = (state_q == ST_LOW)  || (state_q == ST_HIGH) ||
                    (state_q == ST_HOLD) || (state_q == ST_GAP)  ||
                    ((state_q == ST_LOAD) && first_byte);

    spi_clock_divider #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_div (
        .clk_i    (clock),
        .rst_i    (reset),
        .en_i     (div_en),
        .first_o  (ph_first),
        .pre_end_o(ph_pre),
        .end_o    (ph_end)
    );

    assign tx_data_in_ready  = ready_q;
    assign rx_data_out       = rx_q;
    assign rx_data_out_valid = rxv_q;
    assign busy_out          = busy_q;
    assign done_out          = done_q;
    assign spi_select_out    = sel_q;
    assign spi_clock_out     = sck_q;
    assign spi_data_out      = mosi_q;

    // Transaction FSM with registered bus and status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= 8'h00;
            sr_q    <= 7'h00;
            rxsr_q  <= 7'h00;
            rx_q    <= 8'h00;
            rxv_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            sel_q   <= 1'b1;
            sck_q   <= CPOL;
            mosi_q  <= 1'b0;
            ready_q <= 1'b0;
            bit_q   <= 3'd0;
            byte_q  <= 9'd0;
            total_q <= 9'd0;
        end else begin
            rxv_q  <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_in) begin
                        addr_q  <= address_in;
                        total_q <= {1'b0, length_in} + 9'd1;
                        byte_q  <= 9'd0;
                        bit_q   <= 3'd0;
                        busy_q  <= 1'b1;
                        sel_q   <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (first_byte) begin
                        if (ph_end) begin
                            sr_q    <= addr_q[6:0];
                            mosi_q  <= addr_q[7];
                            state_q <= ST_LOW;
                        end
                    end else if (tx_data_in_valid) begin
                        sr_q    <= tx_data_in[6:0];
                        mosi_q  <= tx_data_in[7];
                        ready_q <= 1'b0;
                        state_q <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (ph_end) begin
                        sck_q   <= ~CPOL;
                        state_q <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (ph_first) begin
                        rxsr_q <= {rxsr_q[5:0], spi_data_in};
                        if ((bit_q == 3'd7) && !first_byte) begin
                            rx_q  <= {rxsr_q, spi_data_in};
                            rxv_q <= 1'b1;
                        end
                    end
                    if (ph_end) begin
                        sck_q <= CPOL;
                        sr_q  <= {sr_q[5:0], 1'b0};
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            byte_q <= byte_q + 9'd1;
                            mosi_q <= 1'b0;
                            if ((byte_q + 9'd1) < total_q) begin
                                ready_q <= 1'b1;
                                state_q <= ST_LOAD;
                            end else begin
                                state_q <= ST_HOLD;
                            end
                        end else begin
                            mosi_q  <= sr_q[6];
                            state_q <= ST_LOW;
                        end
                    end
                end
                ST_HOLD: begin
                    if (ph_end) begin
                        sel_q   <= 1'b1;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (ph_pre) begin
                        done_q <= 1'b1;
                    end
                    if (ph_end) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: peripheral models, rx/tx
// queues, directed transactions at HALF_PERIOD 4 and 2.
module tb_spi_controller;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic       start1 = 0, txv1 = 0, miso1 = 0;
    logic [7:0] addr1 = 0, len1 = 0, txd1 = 0;
    logic       txr1, rxv1, busy1, done1, sel1, sck1, mosi1;
    logic [7:0] rxd1;

    logic       start2 = 0, txv2 = 0, miso2 = 0;
    logic [7:0] addr2 = 0, len2 = 0, txd2 = 0;
    logic       txr2, rxv2, busy2, done2, sel2, sck2, mosi2;
    logic [7:0] rxd2;

    spi_controller #(.HALF_PERIOD(4)) u1 (
        .clock(clock), .reset(reset), .start_in(start1),
        .address_in(addr1), .length_in(len1),
        .tx_data_in(txd1), .tx_data_in_valid(txv1),
        .tx_data_in_ready(txr1), .rx_data_out(rxd1),
        .rx_data_out_valid(rxv1), .busy_out(busy1),
        .done_out(done1), .spi_select_out(sel1),
        .spi_clock_out(sck1), .spi_data_out(mosi1),
        .spi_data_in(miso1)
    );

    spi_controller #(.HALF_PERIOD(2)) u2 (
        .clock(clock), .reset(reset), .start_in(start2),
        .address_in(addr2), .length_in(len2),
        .tx_data_in(txd2), .tx_data_in_valid(txv2),
        .tx_data_in_ready(txr2), .rx_data_out(rxd2),
        .rx_data_out_valid(rxv2), .busy_out(busy2),
        .done_out(done2), .spi_select_out(sel2),
        .spi_clock_out(sck2), .spi_data_out(mosi2),
        .spi_data_in(miso2)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out", name);
    endtask

    // ---------------- DUT 1 scoreboard and peripheral ----------------
    logic [7:0] exp_mosi[$];
    logic [7:0] miso_q[$];
    logic [7:0] exp_rx[$];
    logic [7:0] tx_src[$];
    logic [7:0] rsp_src[$];
    logic [7:0] psr = 0, pbyte = 0;
    int pcnt = 0;
    int edges1 = 0, dones1 = 0, rxp1 = 0, hs1 = 0, sellow1 = 0;

    always @(posedge sck1) edges1++;

    always @(negedge clock) begin
        if (done1) dones1++;
        if (!sel1) sellow1++;
        if (txv1 && txr1) hs1++;
        if (rxv1) begin
            rxp1++;
            if (exp_rx.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rx_unexpected: got %02h, none expected", rxd1);
            end else begin
                check("rx_byte", rxd1, exp_rx.pop_front());
            end
        end
    end

    always @(negedge sel1) begin
        pcnt = 0;
        pbyte = 8'h00;
        if (miso_q.size() > 0) pbyte = miso_q.pop_front();
        miso1 = pbyte[7];
    end

    always @(posedge sck1) begin
        if (sel1 == 1'b0) begin
            psr = {psr[6:0], mosi1};
            pcnt++;
            if (pcnt % 8 == 0) begin
                if (exp_mosi.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL mosi_unexpected: got %02h", psr);
                end else begin
                    check("mosi_byte", psr, exp_mosi.pop_front());
                end
            end
        end
    end

    always @(negedge sck1) begin
        if (sel1 == 1'b0) begin
            if (pcnt % 8 == 0) begin
                pbyte = 8'h00;
                if (miso_q.size() > 0) pbyte = miso_q.pop_front();
            end else begin
                pbyte = {pbyte[6:0], 1'b0};
            end
            miso1 = pbyte[7];
        end
    end

    // ---------------- DUT 2 peripheral and counters ----------------
    logic [7:0] psr2 = 0, pb2 = 0;
    int pcnt2 = 0, pbytes2 = 0;
    int edges2 = 0, dones2 = 0, rxp2 = 0, hs2 = 0;

    always @(posedge sck2) edges2++;

    always @(negedge clock) begin
        if (done2) dones2++;
        if (txv2 && txr2) hs2++;
        if (rxv2) begin
            rxp2++;
            check("rx2_byte", rxd2, 32'(rxp2 & 255));
        end
    end

    always @(negedge sel2) begin
        pcnt2 = 0;
        pb2 = 8'h00;
        miso2 = 1'b0;
    end

    always @(posedge sck2) begin
        if (sel2 == 1'b0) begin
            psr2 = {psr2[6:0], mosi2};
            pcnt2++;
            if (pcnt2 % 8 == 0) begin
                pbytes2++;
                if (pcnt2 == 8) check("mosi2_addr", psr2, 8'hA7);
                else check("mosi2_byte", psr2, 8'(pcnt2 / 8 - 1) ^ 8'h5A);
            end
        end
    end

    always @(negedge sck2) begin
        if (sel2 == 1'b0) begin
            if (pcnt2 % 8 == 0) pb2 = 8'(pcnt2 / 8);
            else pb2 = {pb2[6:0], 1'b0};
            miso2 = pb2[7];
        end
    end

    // ---------------- DUT 1 stimulus ----------------
    task automatic drive1(input int stall_idx);
        int k;
        int e0;
        int bad;
        for (int i = 0; i < tx_src.size(); i++) begin
            if (i == stall_idx) begin
                txv1 = 1'b0;
                k = 0;
                while (txr1 !== 1'b1 && k < 5000) begin
                    @(negedge clock);
                    k++;
                end
                e0 = edges1;
                bad = 0;
                repeat (20) begin
                    @(negedge clock);
                    if (sck1 !== 1'b0 || sel1 !== 1'b0 || txr1 !== 1'b1)
                        bad++;
                end
                check("stall_lines", bad, 0);
                check("stall_edges", edges1 - e0, 0);
            end
            txd1 = tx_src[i];
            txv1 = 1'b1;
            k = 0;
            while (txr1 !== 1'b1 && k < 5000) begin
                @(negedge clock);
                k++;
            end
            if (k >= 5000) begin
                timeout("tx_handshake");
                txv1 = 1'b0;
                return;
            end
            @(posedge clock);
            #1;
        end
        txv1 = 1'b0;
    endtask

    task automatic start1_pulse(input logic [7:0] a, input logic [7:0] l);
        @(negedge clock);
        addr1 = a;
        len1 = l;
        start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
    endtask

    task automatic load_queues(input logic [7:0] a);
        exp_mosi.push_back(a);
        foreach (tx_src[i]) exp_mosi.push_back(tx_src[i]);
        miso_q.push_back(8'hFF);
        foreach (rsp_src[i]) begin
            miso_q.push_back(rsp_src[i]);
            exp_rx.push_back(rsp_src[i]);
        end
        edges1 = 0;
        dones1 = 0;
        rxp1 = 0;
        hs1 = 0;
        sellow1 = 0;
    endtask

    task automatic txn1(input logic [7:0] a, input logic [7:0] l,
                        input int stall, input bit extra);
        int k;
        load_queues(a);
        start1_pulse(a, l);
        check("busy_after_start", busy1, 1);
        fork
            drive1(stall);
            begin
                if (extra) begin
                    repeat (40) @(negedge clock);
                    check("busy_mid", busy1, 1);
                    start1 = 1'b1;
                    @(negedge clock);
                    start1 = 1'b0;
                end
            end
        join
        k = 0;
        while (dones1 == 0 && k < 20000) begin
            @(negedge clock);
            k++;
        end
        if (k >= 20000) timeout("done_wait");
        repeat (60) @(negedge clock);
        check("sck_edges", edges1, 8 * (1 + int'(l)));
        check("done_count", dones1, 1);
        check("rx_pulses", rxp1, l);
        check("tx_handshakes", hs1, l);
        check("busy_idle", busy1, 0);
        check("select_idle", sel1, 1);
        check("mosi_idle", mosi1, 0);
        check("mosi_left", exp_mosi.size(), 0);
        check("rx_left", exp_rx.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) @(negedge clock);
        check("rst_select", sel1, 1);
        check("rst_sck", sck1, 0);
        check("rst_mosi", mosi1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_ready", txr1, 0);
        check("rst_rxv", rxv1, 0);
        check("rst_rxd", rxd1, 0);
        check("rst2_select", sel2, 1);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // address only
        tx_src = {};
        rsp_src = {};
        txn1(8'hDB, 8'd0, -1, 1'b0);
        check("A_select_low", sellow1, 72);
        check("A_rx_hold", rxd1, 8'h00);

        // two data bytes
        tx_src = '{8'hA5, 8'h3C};
        rsp_src = '{8'h81, 8'h7E};
        txn1(8'h20, 8'd2, -1, 1'b0);
        check("B_select_low", sellow1, 202);
        check("B_rx_hold", rxd1, 8'h7E);

        // stall before second data byte
        tx_src = '{8'h11, 8'hE7, 8'h5C};
        rsp_src = '{8'hF0, 8'h0F, 8'h96};
        txn1(8'hC5, 8'd3, 1, 1'b0);

        // start while busy
        tx_src = '{8'h99};
        rsp_src = '{8'hC3};
        txn1(8'h5A, 8'd1, -1, 1'b1);

        // reset during bit 3 of the data byte
        tx_src = '{8'h6B};
        rsp_src = '{8'hB4};
        load_queues(8'hE1);
        start1_pulse(8'hE1, 8'd1);
        fork
            drive1(-1);
            begin
                k = 0;
                while (edges1 < 12 && k < 5000) begin
                    @(negedge clock);
                    k++;
                end
                if (k >= 5000) timeout("reset_edge_wait");
            end
        join
        reset = 1'b1;
        @(negedge clock);
        check("E_select", sel1, 1);
        check("E_sck", sck1, 0);
        check("E_busy", busy1, 0);
        check("E_rxd", rxd1, 8'h00);
        reset = 1'b0;
        repeat (200) @(negedge clock);
        check("E_no_done", dones1, 0);
        check("E_no_rx", rxp1, 0);
        check("E_mosi_partial", exp_mosi.size(), 1);
        exp_mosi.delete();
        miso_q.delete();
        exp_rx.delete();

        // clean transaction after abort
        tx_src = '{8'h42};
        rsp_src = '{8'h24};
        txn1(8'h3C, 8'd1, -1, 1'b0);
        check("F_select_low", sellow1, 137);
        check("F_rx_hold", rxd1, 8'h24);

        // HALF_PERIOD 2, 255 data bytes
        @(negedge clock);
        addr2 = 8'hA7;
        len2 = 8'd255;
        start2 = 1'b1;
        @(negedge clock);
        start2 = 1'b0;
        for (int b = 1; b <= 255; b++) begin
            txd2 = 8'(b) ^ 8'h5A;
            txv2 = 1'b1;
            k = 0;
            while (txr2 !== 1'b1 && k < 5000) begin
                @(negedge clock);
                k++;
            end
            if (k >= 5000) begin
                timeout("tx2_handshake");
                break;
            end
            @(posedge clock);
            #1;
        end
        txv2 = 1'b0;
        k = 0;
        while (dones2 == 0 && k < 20000) begin
            @(negedge clock);
            k++;
        end
        if (k >= 20000) timeout("done2_wait");
        repeat (20) @(negedge clock);
        check("G_sck_edges", edges2, 2048);
        check("G_rx_pulses", rxp2, 255);
        check("G_tx_handshakes", hs2, 255);
        check("G_bytes_seen", pbytes2, 256);
        check("G_done_count", dones2, 1);
        check("G_busy_idle", busy2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameter HALF_PERIOD, default 4, SPI clock half-period in system clock cycles; legal range 2..255.
REQ-002 clock  input  1  system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start_in  input  1  one-cycle request to begin a transaction; sampled only in IDLE.
REQ-005 address_in  input  8  subperipheral address; captured on accepted start_in.
REQ-006 length_in  input  8  data bytes after the address byte, 0..255; captured on accepted start_in.
REQ-007 tx_data_in  input  8  next outgoing data byte.
REQ-008 tx_data_in_valid  input  1  tx_data_in holds a byte.
REQ-009 tx_data_in_ready  output  1  byte accepted this cycle when high with tx_data_in_valid.
REQ-010 rx_data_out  output  8  last received data byte.
REQ-011 rx_data_out_valid  output  1  one-cycle pulse; rx_data_out is new.
REQ-012 busy_out  output  1  high from the cycle after an accepted start_in until return to IDLE.
REQ-013 done_out  output  1  one-cycle pulse on completion.
REQ-014 spi_select_out  output  1  active-low chip select.
REQ-015 spi_clock_out  output  1  SPI clock, mode 0 (idle low).
REQ-016 spi_data_out  output  1  controller-to-peripheral data, MSB first.
REQ-017 spi_data_in  input  1  peripheral-to-controller data; already synchronised upstream.

Function
REQ-018 States SHALL be IDLE, LOAD, LOW, HIGH, HOLD, GAP.
- IDLE -> LOAD on start_in; start_in in any other state ignored.
- LOAD: shift register <= address (first byte) or tx_data_in (data byte); tx_data_in_ready high only when loading a data byte; stays in LOAD while tx_data_in_valid low (SCK held low, select held low); -> LOW.
- LOW: SCK low HALF_PERIOD cycles, spi_data_out = current MSB; -> HIGH.
- HIGH: SCK high HALF_PERIOD cycles; spi_data_in sampled into receive register in first HIGH cycle; shift on exit; after bit 7 -> LOAD if bytes remain, else HOLD; otherwise -> LOW.
- HOLD: SCK low, select low HALF_PERIOD cycles; -> GAP.
- GAP: select high HALF_PERIOD cycles; -> IDLE with done_out pulse in last GAP cycle.
REQ-019 spi_select_out SHALL go low in the first LOAD cycle and high on entry to GAP.
REQ-020 Byte counter SHALL be 9 bits (address + up to 255 data bytes); length_in=0 SHALL send the address only with no tx handshake and no rx pulse.
REQ-021 Bits received during the address byte SHALL be discarded; rx_data_out_valid SHALL pulse in the cycle after the 8th sample of each data byte.
REQ-022 rx_data_out SHALL hold its value between pulses.
REQ-023 spi_data_out SHALL be 0 outside LOW/HIGH.
REQ-024 Total SCK rising edges per transaction SHALL equal 8*(1+length).

Reset
REQ-025 In the cycle after reset is sampled high: state IDLE, spi_select_out 1, spi_clock_out 0, spi_data_out 0, busy_out 0, done_out 0, tx_data_in_ready 0, rx_data_out_valid 0, rx_data_out 0x00.
REQ-026 Reset mid-transaction SHALL abort without done_out or rx_data_out_valid pulses.

Structure
REQ-027 State enum and SPI mode constant SHALL live in shared package spi_pkg alongside existing SPI definitions.
REQ-028 SCK/bit timing SHALL be a sub-module spi_clock_divider (half-period counter producing phase-end strobe); FSM stays in spi_controller.

Verification
REQ-029 HALF_PERIOD=4, address 0xDB, length 0, peripheral model -> 8 SCK edges, MOSI 11011011, select low 4+64+4 cycles, one done_out, no rx pulse.
REQ-030 Address 0x20, length 2, tx 0xA5,0x3C, MISO returns 0x81,0x7E -> peripheral receives 20 A5 3C; rx pulses 0x81 then 0x7E; 24 SCK edges.
REQ-031 tx_data_in_valid withheld 20 cycles before second data byte -> SCK low and select low throughout stall, no extra edges, data intact.
REQ-032 start_in pulsed while busy_out high -> ignored, exactly one transaction completes.
REQ-033 Reset asserted during bit 3 of data byte -> next cycle select 1, SCK 0, busy 0; no done_out; subsequent transaction correct.
REQ-034 HALF_PERIOD=2, length 255 -> 2048 SCK edges, 255 rx pulses, 255 tx handshakes, byte counter no wrap.
